inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 156 +++++++++++++++
 tb/tb_inst_fetch.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch
//  Description : Instruction fetch front end. Issues word-aligned fetch
//                requests under a two-slot credit scheme, buffers returned
//                words in a 2-entry in-order queue with their PCs, and
//                supports a single-cycle redirect that flushes the queue and
//                discards every response still in flight.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   1  clock, rising edge
//    rst            in   1  asynchronous active-high reset
//    imem_req_valid out  1  fetch request valid
//    imem_req_addr  out 32  word-aligned fetch address
//    imem_req_ready in   1  memory accepts the request
//    imem_rsp_valid in   1  instruction word returned (in request order)
//    imem_rsp_data  in  32  returned instruction word
//    redirect_valid in   1  change the fetch stream this cycle
//    redirect_pc    in  32  new fetch address (bits [1:0] ignored)
//    inst_valid     out  1  instruction available to decode
//    inst           out 32  instruction word (0 when nothing buffered)
//    inst_pc        out 32  address of inst (0 when nothing buffered)
//    inst_ready     in   1  decode consumes inst this cycle
// ============================================================================
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam logic [31:0] C_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] C_PC_STEP    = 32'd4;
  localparam logic [2:0]  C_DEPTH      = 3'd2;

  // PCs are kept word-aligned in the registers themselves.
  logic [31:0] r_fetch_pc, r_head_pc;
  logic [31:0] r_buf0, r_buf1;      // r_buf0 is always the head entry
  logic [1:0]  r_count, r_outstanding, r_drop;

  logic [31:0] w_fetch_pc_nxt, w_head_pc_nxt;
  logic [31:0] w_buf0_nxt, w_buf1_nxt;
  logic [1:0]  w_count_nxt, w_outstanding_nxt, w_drop_nxt;

  logic        w_credit_ok;
  logic        w_req_fire, w_rsp_fire, w_push, w_pop;
  logic [31:0] w_redirect_pc;

  // Buffered plus in-flight words never exceed the buffer depth, so a
  // response can always be pushed without checking for space.
  assign w_credit_ok    = ({1'b0, r_outstanding} + {1'b0, r_count}) < C_DEPTH;
  assign imem_req_valid = w_credit_ok && !redirect_valid && !rst;
  assign imem_req_addr  = r_fetch_pc;

  assign w_req_fire    = imem_req_valid && imem_req_ready;
  // A response with nothing outstanding is stray and has no effect.
  assign w_rsp_fire    = imem_rsp_valid && (r_outstanding != 2'd0);
  assign w_push        = w_rsp_fire && (r_drop == 2'd0);
  assign w_pop         = inst_valid && inst_ready;
  assign w_redirect_pc = redirect_pc & C_ALIGN_MASK;

  assign inst_valid = (r_count != 2'd0);
  assign inst       = inst_valid ? r_buf0    : 32'd0;
  assign inst_pc    = inst_valid ? r_head_pc : 32'd0;

  always_comb begin
    w_fetch_pc_nxt    = r_fetch_pc;
    w_head_pc_nxt     = r_head_pc;
    w_buf0_nxt        = r_buf0;
    w_buf1_nxt        = r_buf1;
    w_count_nxt       = r_count;
    w_outstanding_nxt = r_outstanding;
    w_drop_nxt        = r_drop;

    if (redirect_valid) begin
      // No request can fire this cycle; any response is thrown away and
      // everything still in flight afterwards must be discarded on return.
      w_count_nxt       = 2'd0;
      w_fetch_pc_nxt    = w_redirect_pc;
      w_head_pc_nxt     = w_redirect_pc;
      w_outstanding_nxt = r_outstanding - {1'b0, w_rsp_fire};
      w_drop_nxt        = w_outstanding_nxt;
    end else begin
      if (w_req_fire) begin
        w_fetch_pc_nxt = r_fetch_pc + C_PC_STEP;
      end
      if (w_pop) begin
        w_head_pc_nxt = r_head_pc + C_PC_STEP;
      end
      w_outstanding_nxt = r_outstanding + {1'b0, w_req_fire} - {1'b0, w_rsp_fire};
      if (w_rsp_fire && (r_drop != 2'd0)) begin
        w_drop_nxt = r_drop - 2'd1;
      end

      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            w_buf0_nxt = imem_rsp_data;
          end else begin
            w_buf1_nxt = imem_rsp_data;
          end
          w_count_nxt = r_count + 2'd1;
        end
        2'b01: begin
          w_buf0_nxt  = r_buf1;
          w_count_nxt = r_count - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new word lands behind whatever remains.
          if (r_count == 2'd1) begin
            w_buf0_nxt = imem_rsp_data;
          end else begin
            w_buf0_nxt = r_buf1;
            w_buf1_nxt = imem_rsp_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC & C_ALIGN_MASK;
      r_head_pc     <= RESET_PC & C_ALIGN_MASK;
      r_buf0        <= 32'd0;
      r_buf1        <= 32'd0;
      r_count       <= 2'd0;
      r_outstanding <= 2'd0;
      r_drop        <= 2'd0;
    end else begin
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_head_pc     <= w_head_pc_nxt;
      r_buf0        <= w_buf0_nxt;
      r_buf1        <= w_buf1_nxt;
      r_count       <= w_count_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_drop        <= w_drop_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_fetch
//  Description : Directed self-checking bench for inst_fetch. Each scenario
//                starts from reset and drives the memory and decode sides
//                cycle by cycle with hand-computed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'd0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = 32'd0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready     = 1'b0;

  int checks = 0;
  int errors = 0;

  inst_fetch #(
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    inst_ready     = 1'b0;
  endtask

  // Leaves the caller just after rst falls, in the first post-reset cycle.
  task automatic do_reset;
    rst = 1'b1;
    idle_inputs();
    tick();
    chk("rst_req_valid",  {31'd0, imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid},     32'd0);
    chk("rst_inst",       inst,                    32'd0);
    chk("rst_inst_pc",    inst_pc,                 32'd0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // ---------------- basic flow, 1-cycle memory ----------------
    do_reset();
    imem_req_ready = 1'b1; inst_ready = 1'b1;
    #1;
    chk("t1_c1_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("t1_c1_req_addr",  imem_req_addr,           32'h0);
    chk("t1_c1_inst_valid",{31'd0, inst_valid},     32'd0);
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0033;
    #1;
    chk("t1_c2_req_addr",  imem_req_addr,           32'h4);
    chk("t1_c2_inst_valid",{31'd0, inst_valid},     32'd0);
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0040_0093;
    #1;
    chk("t1_c3_inst_valid",{31'd0, inst_valid},     32'd1);
    chk("t1_c3_inst",      inst,                    32'h0000_0033);
    chk("t1_c3_inst_pc",   inst_pc,                 32'h0);
    chk("t1_c3_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    chk("t1_c4_inst",      inst,                    32'h0040_0093);
    chk("t1_c4_inst_pc",   inst_pc,                 32'h4);
    chk("t1_c4_req_addr",  imem_req_addr,           32'h8);

    // ---------------- backpressure from decode ----------------
    do_reset();
    imem_req_ready = 1'b1; inst_ready = 1'b0;
    #1;
    chk("t2_c1_req_addr",  imem_req_addr,           32'h0);
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0033;
    #1;
    chk("t2_c2_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("t2_c2_req_addr",  imem_req_addr,           32'h4);
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0040_0093;
    #1;
    chk("t2_c3_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    chk("t2_c4_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("t2_c4_inst",      inst,                    32'h0000_0033);
    chk("t2_c4_inst_pc",   inst_pc,                 32'h0);
    tick();
    inst_ready = 1'b1;
    #1;
    chk("t2_c5_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();
    inst_ready = 1'b0;
    #1;
    chk("t2_c6_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("t2_c6_req_addr",  imem_req_addr,           32'h8);
    chk("t2_c6_inst",      inst,                    32'h0040_0093);
    chk("t2_c6_inst_pc",   inst_pc,                 32'h4);

    // ---------------- redirect with two requests in flight ----------------
    do_reset();
    imem_req_ready = 1'b1; inst_ready = 1'b1;
    #1;
    tick();                                   // request 0x0 accepted
    #1;
    chk("t3_c2_req_addr",  imem_req_addr,           32'h4);
    tick();                                   // request 0x4 accepted
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    #1;
    chk("t3_c3_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_0000;
    #1;
    chk("t3_c4_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_0004;
    #1;
    chk("t3_c5_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("t3_c5_req_addr",  imem_req_addr,           32'h100);
    chk("t3_c5_inst_valid",{31'd0, inst_valid},     32'd0);
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1000_0100;
    #1;
    chk("t3_c6_inst_valid",{31'd0, inst_valid},     32'd0);
    chk("t3_c6_req_addr",  imem_req_addr,           32'h104);
    tick();
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b0;
    #1;
    chk("t3_c7_inst_valid",{31'd0, inst_valid},     32'd1);
    chk("t3_c7_inst",      inst,                    32'h1000_0100);
    chk("t3_c7_inst_pc",   inst_pc,                 32'h100);

    // ---------------- redirect colliding with response and pop ----------------
    do_reset();
    imem_req_ready = 1'b1; inst_ready = 1'b1;
    #1;
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0033;
    #1;
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0040_0093;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    #1;
    chk("t4_c3_inst_valid",{31'd0, inst_valid},     32'd1);
    chk("t4_c3_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();
    imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
    #1;
    chk("t4_c4_inst_valid",{31'd0, inst_valid},     32'd0);
    chk("t4_c4_inst",      inst,                    32'h0);
    chk("t4_c4_inst_pc",   inst_pc,                 32'h0);
    chk("t4_c4_req_addr",  imem_req_addr,           32'h200);
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1000_0200;
    #1;
    tick();
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b0;
    #1;
    chk("t4_c6_inst_valid",{31'd0, inst_valid},     32'd1);
    chk("t4_c6_inst",      inst,                    32'h1000_0200);
    chk("t4_c6_inst_pc",   inst_pc,                 32'h200);

    // ---------------- address wrap at the top of memory ----------------
    do_reset();
    imem_req_ready = 1'b1; inst_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    #1;
    chk("t5_c1_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("t5_c2_req_addr",  imem_req_addr,           32'hFFFF_FFFC);
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1111_1111;
    #1;
    chk("t5_c3_req_addr",  imem_req_addr,           32'h0);
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h2222_2222; inst_ready = 1'b1;
    #1;
    chk("t5_c4_inst",      inst,                    32'h1111_1111);
    chk("t5_c4_inst_pc",   inst_pc,                 32'hFFFF_FFFC);
    tick();
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b0;
    #1;
    chk("t5_c5_inst_valid",{31'd0, inst_valid},     32'd1);
    chk("t5_c5_inst",      inst,                    32'h2222_2222);
    chk("t5_c5_inst_pc",   inst_pc,                 32'h0);
    chk("t5_c5_req_addr",  imem_req_addr,           32'h4);

    // ---------------- reset mid-operation (one buffered, one in flight) ----------------
    do_reset();
    imem_req_ready = 1'b1; inst_ready = 1'b0;
    #1;
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0033;
    #1;
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    chk("t6_pre_inst_valid",{31'd0, inst_valid},    32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_inst_valid",{31'd0, inst_valid},    32'd0);
    chk("t6_rst_inst",      inst,                   32'h0);
    chk("t6_rst_inst_pc",   inst_pc,                32'h0);
    chk("t6_rst_req_valid", {31'd0, imem_req_valid},32'd0);
    tick();
    rst = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_BAD0;
    #1;
    chk("t6_c1_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("t6_c1_req_addr",  imem_req_addr,           32'h0);
    tick();
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b0;
    #1;
    chk("t6_c2_inst_valid",{31'd0, inst_valid},     32'd0);
    chk("t6_c2_req_addr",  imem_req_addr,           32'h4);
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0077;
    #1;
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    chk("t6_c4_inst_valid",{31'd0, inst_valid},     32'd1);
    chk("t6_c4_inst",      inst,                    32'h0000_0077);
    chk("t6_c4_inst_pc",   inst_pc,                 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
